// File: rtl/central_pkg.sv
// rtl/central_pkg.sv - shared size constants and scheduler state type for central
package central_pkg;

  localparam int I_S = 12;  // memory word width
  localparam int D_S = 8;   // core data width
  localparam int O_S = 4;   // opcode width
  localparam int A_S = 5;   // memory address width
  localparam int P_S = 16;  // program region words
  localparam int STARVE_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_HALT
  } sched_state_t;

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating count of denied host cycles with limit flag
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  // Clear wins over increment; the count parks at LIMIT until the host is served.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == W'(LIMIT));

endmodule

// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - program loader and core/host arbiter for the shared memory port
module mem_port_sched
  import central_pkg::*;
#(
  parameter int INSTR_SIZE   = I_S,
  parameter int DATA_SIZE    = D_S,
  parameter int ADDR_SIZE    = A_S,
  parameter int PROGRAM_SIZE = P_S,
  parameter int STARVE_LIMIT = STARVE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_load,
  input  logic                  host_wr_valid,
  output logic                  host_wr_ready,
  input  logic [INSTR_SIZE-1:0] host_wr_data,
  input  logic                  host_rd_req,
  input  logic [ADDR_SIZE-1:0]  host_rd_addr,
  output logic                  host_rd_gnt,
  output logic                  host_rd_valid,
  output logic [INSTR_SIZE-1:0] host_rd_data,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_SIZE-1:0]  core_addr,
  input  logic [DATA_SIZE-1:0]  core_wdata,
  output logic                  core_gnt,
  output logic [INSTR_SIZE-1:0] core_rdata,
  input  logic                  core_oob,
  output logic                  core_run,
  output logic                  pc_clear,
  output logic                  halted,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  output logic [INSTR_SIZE-1:0] mem_wdata,
  input  logic [INSTR_SIZE-1:0] mem_rdata
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(PROGRAM_SIZE - 1);

  sched_state_t         state;
  logic [ADDR_SIZE-1:0] load_cnt;
  logic                 core_rd_pend;
  logic                 starve_hit;
  logic                 starve_inc;

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (starve_inc),
    .clr     (host_rd_gnt),
    .at_limit(starve_hit)
  );

  assign starve_inc = (state == S_RUN) && host_rd_req && !host_rd_gnt;

  // Port arbitration: host wins in RUN only when the core is quiet or the host has starved.
  always_comb begin
    core_gnt    = 1'b0;
    host_rd_gnt = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE, S_HALT: host_rd_gnt = host_rd_req;
        S_RUN: begin
          host_rd_gnt = host_rd_req && (!core_req || starve_hit);
          core_gnt    = core_req && !host_rd_gnt;
        end
        default: ;
      endcase
    end
  end

  // Memory port mux: load stream, then host read, then core access.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst && (state == S_LOAD) && host_wr_valid) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = load_cnt;
      mem_wdata = host_wr_data;
    end else if (host_rd_gnt) begin
      mem_en   = 1'b1;
      mem_addr = host_rd_addr;
    end else if (core_gnt) begin
      mem_en   = 1'b1;
      mem_we   = core_we;
      mem_addr = core_addr;
      if (core_we) begin
        mem_wdata = {{(INSTR_SIZE - DATA_SIZE){1'b0}}, core_wdata};
      end
    end
  end

  // Sequencer: state plus the registered status outputs that follow it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      load_cnt      <= '0;
      host_wr_ready <= 1'b0;
      pc_clear      <= 1'b0;
      core_run      <= 1'b0;
      halted        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host_load) begin
            state         <= S_LOAD;
            load_cnt      <= '0;
            host_wr_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (host_wr_valid) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == LAST_ADDR) begin
              state         <= S_START;
              host_wr_ready <= 1'b0;
              pc_clear      <= 1'b1;
            end
          end
        end
        S_START: begin
          state    <= S_RUN;
          pc_clear <= 1'b0;
          core_run <= 1'b1;
        end
        S_RUN: begin
          if (core_oob) begin
            state    <= S_HALT;
            core_run <= 1'b0;
            halted   <= 1'b1;
          end
        end
        S_HALT: begin
          if (host_load) begin
            state         <= S_LOAD;
            load_cnt      <= '0;
            halted        <= 1'b0;
            host_wr_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Remember which requester owns the read data arriving next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_rd_valid <= 1'b0;
      core_rd_pend  <= 1'b0;
    end else begin
      host_rd_valid <= host_rd_gnt;
      core_rd_pend  <= core_gnt && !core_we;
    end
  end

  assign host_rd_data = host_rd_valid ? mem_rdata : '0;
  assign core_rdata   = core_rd_pend ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_sched.sv
// tb/tb_mem_port_sched.sv - table and sequence driven bench for mem_port_sched
module tb_mem_port_sched;

  logic        clk;
  logic        rst;
  logic        host_load;
  logic        host_wr_valid;
  logic        host_wr_ready;
  logic [11:0] host_wr_data;
  logic        host_rd_req;
  logic [4:0]  host_rd_addr;
  logic        host_rd_gnt;
  logic        host_rd_valid;
  logic [11:0] host_rd_data;
  logic        core_req;
  logic        core_we;
  logic [4:0]  core_addr;
  logic [7:0]  core_wdata;
  logic        core_gnt;
  logic [11:0] core_rdata;
  logic        core_oob;
  logic        core_run;
  logic        pc_clear;
  logic        halted;
  logic        mem_en;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  logic        preload;
  logic [11:0] mem   [0:31];
  logic [11:0] model [0:31];
  logic [11:0] hq[$];
  logic [11:0] cq[$];
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [4:0]  c_addr;
    logic [7:0]  c_wdata;
    logic        h_req;
    logic [4:0]  h_addr;
    logic        e_core;
    logic        e_host;
    logic        e_en;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [11:0] e_wdata;
  } vec_t;

  vec_t vt [8];

  mem_port_sched dut (
    .clk          (clk),
    .rst          (rst),
    .host_load    (host_load),
    .host_wr_valid(host_wr_valid),
    .host_wr_ready(host_wr_ready),
    .host_wr_data (host_wr_data),
    .host_rd_req  (host_rd_req),
    .host_rd_addr (host_rd_addr),
    .host_rd_gnt  (host_rd_gnt),
    .host_rd_valid(host_rd_valid),
    .host_rd_data (host_rd_data),
    .core_req     (core_req),
    .core_we      (core_we),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_gnt     (core_gnt),
    .core_rdata   (core_rdata),
    .core_oob     (core_oob),
    .core_run     (core_run),
    .pc_clear     (pc_clear),
    .halted       (halted),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port memory with one-cycle synchronous read
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 12'hA00 + 12'(i);
      mem_rdata <= 12'h000;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    host_load = 0; host_wr_valid = 0; host_wr_data = 0;
    host_rd_req = 0; host_rd_addr = 0;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_oob = 0;
  endtask

  task automatic step();
    tick();
    clr_in();
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {core_run, pc_clear, halted, host_wr_ready, host_rd_gnt, host_rd_valid,
              core_gnt, mem_en, mem_we, mem_addr, mem_wdata, core_rdata, host_rd_data}, 64'd0);
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < 16; i++) chk(tag, {mem[i]}, {model[i]});
  endtask

  // read-return scoreboard: every expected grant must return its word exactly one cycle later
  always begin : mon
    logic [11:0] e;
    @(posedge clk);
    #2;
    if (hq.size() > 0) begin
      e = hq.pop_front();
      chk("host_rd_valid", host_rd_valid, 1);
      chk("host_rd_data", host_rd_data, e);
    end else begin
      chk("host_rd_valid_quiet", host_rd_valid, 0);
    end
    if (cq.size() > 0) begin
      e = cq.pop_front();
      chk("core_rdata", core_rdata, e);
    end
  end

  task automatic do_load(input logic [11:0] base, input bit gaps, input string tag);
    int w;
    w = 0;
    for (int c = 0; w < 16; c++) begin
      step();
      if (!gaps || (c % 2 == 0)) begin
        host_wr_valid = 1; host_wr_data = base + 12'(w);
        settle();
        chk({tag, "_ready"}, host_wr_ready, 1);
        chk({tag, "_we"}, {mem_en, mem_we}, 2'b11);
        chk({tag, "_addr"}, mem_addr, w);
        chk({tag, "_wdata"}, mem_wdata, base + 12'(w));
        model[w] = base + 12'(w);
        w++;
      end else begin
        host_rd_req = 1; host_rd_addr = 5'd0;
        settle();
        chk({tag, "_gap_ready"}, host_wr_ready, 1);
        chk({tag, "_gap_idle"}, {mem_en, host_rd_gnt}, 2'b00);
      end
    end
    step(); settle();
    chk({tag, "_pc_clear"}, {pc_clear, core_run, host_wr_ready}, 3'b100);
    step(); settle();
    chk({tag, "_core_run"}, {pc_clear, core_run}, 2'b01);
    chk_mem({tag, "_mem"});
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  12'h000};
    vt[1] = '{1'b1, 1'b1, 5'd16, 8'h05, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd16, 12'h005};
    vt[2] = '{1'b1, 1'b0, 5'd16, 8'h00, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd16, 12'h000};
    vt[3] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0, 5'd16, 12'h000};
    vt[4] = '{1'b1, 1'b0, 5'd2,  8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2,  12'h000};
    vt[5] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd5,  1'b0, 1'b1, 1'b1, 1'b0, 5'd5,  12'h000};
    vt[6] = '{1'b1, 1'b1, 5'd17, 8'hFF, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 5'd17, 12'h0FF};
    vt[7] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd17, 1'b0, 1'b1, 1'b1, 1'b0, 5'd17, 12'h000};

    for (int i = 0; i < 32; i++) model[i] = 12'hA00 + 12'(i);
    preload = 1; rst = 1; clr_in();
    tick(); tick();
    preload = 0;
    settle();
    chk_reset("reset_values");

    // host read served in IDLE
    step(); rst = 0;
    host_rd_req = 1; host_rd_addr = 5'd3;
    settle();
    chk("idle_host_gnt", {host_rd_gnt, mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 5'd3});
    hq.push_back(model[3]);

    // start load; IDLE itself makes no access
    step(); host_load = 1;
    settle();
    chk("idle_no_access", {mem_en, host_wr_ready}, 2'b00);
    do_load(12'h500, 1'b0, "load_full");

    // arbitration table in RUN
    foreach (vt[r]) begin
      step();
      core_req = vt[r].c_req; core_we = vt[r].c_we;
      core_addr = vt[r].c_addr; core_wdata = vt[r].c_wdata;
      host_rd_req = vt[r].h_req; host_rd_addr = vt[r].h_addr;
      settle();
      chk($sformatf("vec%0d_gnt", r), {core_gnt, host_rd_gnt}, {vt[r].e_core, vt[r].e_host});
      chk($sformatf("vec%0d_port", r), {mem_en, mem_we}, {vt[r].e_en, vt[r].e_we});
      if (vt[r].e_en) chk($sformatf("vec%0d_addr", r), mem_addr, vt[r].e_addr);
      if (vt[r].e_we) chk($sformatf("vec%0d_wdata", r), mem_wdata, vt[r].e_wdata);
      if (vt[r].e_host) hq.push_back(model[vt[r].h_addr]);
      if (vt[r].e_core && !vt[r].c_we) cq.push_back(model[vt[r].c_addr]);
      if (vt[r].e_core && vt[r].c_we) model[vt[r].c_addr] = {4'h0, vt[r].c_wdata};
    end

    // starvation: host forced on its fifth consecutive request, then core resumes
    for (int k = 0; k < 5; k++) begin
      step();
      core_req = 1; core_addr = 5'd1; host_rd_req = 1; host_rd_addr = 5'd16;
      settle();
      if (k < 4) begin
        chk("starve_core_gnt", {core_gnt, host_rd_gnt}, 2'b10);
        cq.push_back(model[1]);
      end else begin
        chk("starve_forced", {core_gnt, host_rd_gnt, mem_addr}, {1'b0, 1'b1, 5'd16});
        hq.push_back(model[16]);
      end
    end
    step(); core_req = 1; core_addr = 5'd2;
    settle();
    chk("starve_released", {core_gnt, host_rd_gnt}, 2'b10);
    cq.push_back(model[2]);

    // out_of_bounds on the same cycle as a forced host grant
    for (int k = 0; k < 5; k++) begin
      step();
      core_req = 1; core_addr = 5'd1; host_rd_req = 1; host_rd_addr = 5'd16;
      core_oob = (k == 4);
      settle();
      if (k < 4) cq.push_back(model[1]);
      else hq.push_back(model[16]);
      chk("oob_gnt", {core_gnt, host_rd_gnt}, (k < 4) ? 2'b10 : 2'b01);
    end
    step(); core_req = 1; host_rd_req = 1; host_rd_addr = 5'd4;
    settle();
    chk("halt_status", {halted, core_run}, 2'b10);
    chk("halt_host_only", {core_gnt, host_rd_gnt}, 2'b01);
    hq.push_back(model[4]);

    // reload from HALT with valid gaps
    step(); host_load = 1;
    settle();
    chk("halt_before_reload", {halted, host_wr_ready}, 2'b10);
    do_load(12'h600, 1'b1, "load_gaps");

    // host_load ignored while running
    step(); host_load = 1;
    settle();
    step(); settle();
    chk("run_ignores_load", {core_run, host_wr_ready, pc_clear, halted}, 4'b1000);

    // reset in the middle of a load
    step(); rst = 1;
    step(); rst = 0;
    settle();
    chk_reset("reset_from_run");
    step(); host_load = 1;
    for (int i = 0; i < 7; i++) begin
      step(); host_wr_valid = 1; host_wr_data = 12'h700 + 12'(i);
      model[i] = 12'h700 + 12'(i);
    end
    step(); rst = 1; host_rd_req = 1; host_rd_addr = 5'd2;
    step(); rst = 0;
    settle();
    chk_reset("reset_in_load");
    chk_mem("mem_after_rst");
    step(); host_load = 1;
    step(); host_wr_valid = 1; host_wr_data = 12'h7FF;
    settle();
    chk("reload_from_zero", {mem_we, mem_addr}, {1'b1, 5'd0});
    step();
    step();
    chk("reload_word0", {mem[0]}, 12'h7FF);
    step(); step();
    chk("hq_drained", hq.size(), 0);
    chk("cq_drained", cq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
